duck_flight_ctl: RTL
====================

// Module: duck_flight_ctl
// PURPOSE
// - Upstream of duck_game_logic: produces the duck's top-left position (duck_xpos/duck_ypos) for a 1024x768 @ 65 MHz display.
// - Moves the duck in a bouncing flight path while the hunt is active, freezes it on a hit, drops it to the ground, then respawns it.
// - Consumes hunt_start and duck_killed from duck_game_logic; its position feeds the hit test and the sprite renderer.
// PARAMETERS
// - TICK_CYCLES   1_083_333  clk cycles per motion tick (~60 Hz); tests use 4
// - SPEED_X       4          px per tick, horizontal
// - SPEED_Y       3          px per tick, vertical, flight
// - FALL_STEP     6          px per tick, vertical, falling
// - HIT_TICKS     30         ticks frozen after a hit before falling
// - TURN_TICKS    90         ticks between random horizontal turn checks
// - GROUND_Y      600        y at which the fall ends (duck_game_logic landing threshold)
// PORTS
// - clk             in   1   65 MHz system clock, posedge
// - rst             in   1   reset, asynchronous, active-high
// - hunt_start      in   1   1 = hunting/reloading phase active (from duck_game_logic)
// - duck_killed     in   1   1 = duck hit, held through the death delay (from duck_game_logic)
// - duck_xpos       out  12  duck top-left x
// - duck_ypos       out  12  duck top-left y
// - duck_face_left  out  1   1 = moving left (sprite mirror)
// - duck_falling    out  1   1 in FALL state (renderer selects fall sprite)
// - duck_hit        out  1   1 in HIT state (renderer selects shot sprite)
// BEHAVIOUR
// - Reset: state IDLE; xpos=464, ypos=GROUND_Y-DUCK_HEIGHT (540); face_left=0; falling=0; hit=0; tick cnt=0; LFSR=16'hACE1.
// - Tick: counter 0..TICK_CYCLES-1; 1-cycle tick when cnt==TICK_CYCLES-1, then wraps to 0. Free-running in all states.
// - LFSR: 16-bit Fibonacci (taps 16,14,13,11), steps every clk; never all-zero.
// - Limits: X_MAX=1024-DUCK_WIDTH=928; Y_MIN=0; Y_MAX=GROUND_Y-DUCK_HEIGHT=540.
// - States:
//   - IDLE: position held. -> FLY when hunt_start=1 && duck_killed=0.
//   - FLY: on tick with hunt_start=1, x+=/-=SPEED_X, y+=/-=SPEED_Y. hunt_start=0 -> position frozen, stay FLY.
//     -> HIT when duck_killed=1 (checked every clk, priority over movement in that cycle).
//   - HIT: position frozen; HIT_TICKS ticks counted, then -> FALL.
//   - FALL: on tick y+=FALL_STEP; x held. When y+FALL_STEP >= GROUND_Y, y=GROUND_Y and -> LANDED.
//   - LANDED: y=GROUND_Y held. -> respawn and FLY when duck_killed=0 && hunt_start=1.
// - Respawn (LANDED->FLY and IDLE->FLY):
//   - x = lfsr[9:0] if <=928, else lfsr[9:0]-512; y=540; dir_y=up.
//   - face_left=lfsr[10].
// - Bounce: next x<0 -> x=0, face_left=0; next x>928 -> x=928, face_left=1.
//   - next y<0 -> y=0, dir down; next y>540 -> y=540, dir up.
//   - Corner: both axes flip in the same tick. Signed 13-bit intermediates; no wrap-around.
// - Random turn: every TURN_TICKS flight ticks, if lfsr[0]=1, face_left toggles (ignored if it would leave bounds this tick).
// - duck_killed while IDLE/LANDED: ignored. hunt_start dropping in HIT/FALL: no effect, sequence completes.
// - Outputs registered; duck_falling/duck_hit decoded from registered state, 0 latency vs state.
// STRUCTURE
// - duck_pkg: DUCK_WIDTH=96, DUCK_HEIGHT=60, H_RES=1024, V_RES=768, flight_state_t enum {IDLE,FLY,HIT,FALL,LANDED}.
//   duck_game_logic migrates to the same DUCK_* constants.
// - Sub-module duck_lfsr16 (clk, rst, lfsr[15:0]); also reusable for dog/bird placement.
// - Body: tick counter, FSM (seq + comb next-state), position datapath with clamp.
// TESTING (TICK_CYCLES=4, HIT_TICKS=2, TURN_TICKS=1000)
// - rst=1 mid-flight -> all outputs at reset values in the same cycle; after release stays IDLE at (464,540) with hunt_start=0.
// - hunt_start=1 from IDLE -> x = spawn value from LFSR, y=540; after 1 tick y=537, x changes by 4.
// - Force FLY at x=926 facing right -> next tick x=928, face_left=1; following tick x=924.
// - Corner x=2,y=1, moving left/up -> x=0,y=0; both directions flip; next tick x=4, y=3.
// - duck_killed=1 at y=300 -> duck_hit=1, position frozen 2 ticks; duck_falling=1, y 306, 312...
//   then y=600 exactly, LANDED; duck_killed=0 with hunt_start=1 -> respawn, y=540.
// - hunt_start=0 during FLY for 20 ticks -> xpos/ypos constant; hunt_start=1 -> motion resumes from the frozen point.

Source files
------------

// File: rtl/duck_pkg.sv
// duck_pkg: shared duck sprite geometry, display size and flight state encoding.
package duck_pkg;
    localparam int DUCK_WIDTH  = 96;
    localparam int DUCK_HEIGHT = 60;
    localparam int H_RES       = 1024;
    localparam int V_RES       = 768;
    typedef enum logic [2:0] {IDLE, FLY, HIT, FALL, LANDED} flight_state_t;
endpackage

// File: rtl/duck_flight_if.sv
// duck_flight_if: game-logic control into the flight controller, position/sprite state back out.
interface duck_flight_if;
    logic        hunt_start;
    logic        duck_killed;
    logic [11:0] duck_xpos;
    logic [11:0] duck_ypos;
    logic        duck_face_left;
    logic        duck_falling;
    logic        duck_hit;
    modport master (
        output hunt_start, duck_killed,
        input  duck_xpos, duck_ypos, duck_face_left, duck_falling, duck_hit
    );
    modport slave (
        input  hunt_start, duck_killed,
        output duck_xpos, duck_ypos, duck_face_left, duck_falling, duck_hit
    );
endinterface

// File: rtl/duck_lfsr16.sv
// duck_lfsr16: free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded non-zero.
module duck_lfsr16 (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] lfsr
);
    always_ff @(posedge clk or posedge rst)
        if (rst) lfsr <= 16'hACE1;
        else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
endmodule

// File: rtl/duck_flight_ctl.sv
// duck_flight_ctl: bouncing flight, hit freeze, fall and respawn of the duck sprite position.
module duck_flight_ctl
    import duck_pkg::*;
#(
    parameter int TICK_CYCLES = 1_083_333,
    parameter int SPEED_X     = 4,
    parameter int SPEED_Y     = 3,
    parameter int FALL_STEP   = 6,
    parameter int HIT_TICKS   = 30,
    parameter int TURN_TICKS  = 90,
    parameter int GROUND_Y    = 600
) (
    input logic          clk,
    input logic          rst,
    duck_flight_if.slave bus
);
    localparam int X_MAX = H_RES - DUCK_WIDTH;
    localparam int Y_MAX = GROUND_Y - DUCK_HEIGHT;
    localparam int CW    = $clog2(TICK_CYCLES + 1);
    localparam int HW    = $clog2(HIT_TICKS + 1);
    localparam int TW    = $clog2(TURN_TICKS + 1);
    localparam logic signed [12:0] XM = 13'(X_MAX);
    localparam logic signed [12:0] YM = 13'(Y_MAX);
    localparam logic signed [12:0] SX = 13'(SPEED_X);
    localparam logic signed [12:0] SY = 13'(SPEED_Y);
    localparam logic signed [12:0] FS = 13'(FALL_STEP);
    localparam logic signed [12:0] GY = 13'(GROUND_Y);

    flight_state_t      state, state_n;
    logic [CW-1:0]      cnt;
    logic [HW-1:0]      hit_cnt, hit_n;
    logic [TW-1:0]      turn_cnt, turn_n;
    logic [11:0]        x, y, x_n, y_n;
    logic               face, down, face_n, down_n;
    logic [10:0]        lfsr;
    logic [4:0]         lfsr_unused;
    logic               tick, turn, leave, go_left;
    logic [9:0]         spawn_x;
    logic signed [12:0] xs, ys, xr, xl, nx, ny, fy;

    duck_lfsr16 u_lfsr (.clk(clk), .rst(rst), .lfsr({lfsr_unused, lfsr}));

    assign tick    = cnt == CW'(TICK_CYCLES - 1);
    assign xs      = $signed({1'b0, x});
    assign ys      = $signed({1'b0, y});
    assign xr      = xs + SX;
    assign xl      = xs - SX;
    assign ny      = down ? ys + SY : ys - SY;
    assign fy      = ys + FS;
    // A random turn is dropped when the reversed step would leave the screen.
    assign turn    = turn_cnt == TW'(TURN_TICKS - 1) && lfsr[0];
    assign leave   = face ? xr > XM : xl < 13'sd0;
    assign go_left = (turn && !leave) ? !face : face;
    assign nx      = go_left ? xl : xr;
    assign spawn_x = lfsr[9:0] > 10'(X_MAX) ? lfsr[9:0] - 10'd512 : lfsr[9:0];

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt      <= '0;
            state    <= IDLE;
            x        <= 12'(X_MAX / 2);
            y        <= 12'(Y_MAX);
            face     <= 1'b0;
            down     <= 1'b0;
            hit_cnt  <= '0;
            turn_cnt <= '0;
        end else begin
            cnt      <= tick ? '0 : cnt + 1'b1;
            state    <= state_n;
            x        <= x_n;
            y        <= y_n;
            face     <= face_n;
            down     <= down_n;
            hit_cnt  <= hit_n;
            turn_cnt <= turn_n;
        end

    always_comb begin
        state_n = state;
        x_n     = x;
        y_n     = y;
        face_n  = face;
        down_n  = down;
        hit_n   = hit_cnt;
        turn_n  = turn_cnt;
        case (state)
            IDLE, LANDED:
                if (bus.hunt_start && !bus.duck_killed) begin
                    state_n = FLY;
                    x_n     = {2'b00, spawn_x};
                    y_n     = 12'(Y_MAX);
                    face_n  = lfsr[10];
                    down_n  = 1'b0;
                end
            FLY:
                if (bus.duck_killed) begin
                    state_n = HIT;
                    hit_n   = '0;
                end else if (tick && bus.hunt_start) begin
                    x_n    = nx < 13'sd0 ? 12'd0 : nx > XM ? 12'(X_MAX) : nx[11:0];
                    face_n = nx < 13'sd0 ? 1'b0 : nx > XM ? 1'b1 : go_left;
                    y_n    = ny < 13'sd0 ? 12'd0 : ny > YM ? 12'(Y_MAX) : ny[11:0];
                    down_n = ny < 13'sd0 ? 1'b1 : ny > YM ? 1'b0 : down;
                    turn_n = turn_cnt == TW'(TURN_TICKS - 1) ? '0 : turn_cnt + 1'b1;
                end
            HIT:
                if (tick) begin
                    hit_n   = hit_cnt + 1'b1;
                    state_n = hit_cnt == HW'(HIT_TICKS - 1) ? FALL : HIT;
                end
            FALL:
                if (tick) begin
                    state_n = fy >= GY ? LANDED : FALL;
                    y_n     = fy >= GY ? 12'(GROUND_Y) : fy[11:0];
                end
            default: state_n = IDLE;
        endcase
    end

    assign bus.duck_xpos      = x;
    assign bus.duck_ypos      = y;
    assign bus.duck_face_left = face;
    assign bus.duck_falling   = state == FALL;
    assign bus.duck_hit       = state == HIT;
endmodule
